// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter for FU result ports.
// Squashes younger-than-redirect results and registers wwd winners.
package wb_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] data;
  } exe_bundle_t;

  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] topid;
  } red_bundle_t;
endpackage

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int nfu  = 4,
  parameter int wwd  = 2,
  parameter int opsz = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  red_bundle_t           redir,
  input  exe_bundle_t [nfu-1:0] resp,
  output logic        [nfu-1:0] claim,
  output exe_bundle_t [wwd-1:0] wb
);

  localparam int L  = $clog2(opsz);
  localparam int PW = (nfu > 1) ? $clog2(nfu) : 1;
  localparam int SW = (wwd > 1) ? $clog2(wwd) : 1;

  logic        [PW-1:0]  r_ptr;
  exe_bundle_t [wwd-1:0] r_wb;

  logic        [nfu-1:0] w_live;
  logic        [nfu-1:0] w_dead;
  logic        [nfu-1:0] w_gnt;
  logic        [PW-1:0]  w_ptr_nxt;
  exe_bundle_t [wwd-1:0] w_wb_nxt;

  // Younger than the redirect point, measured relative to topid.
  function automatic logic squash(
    input logic [15:0] x,
    input red_bundle_t r
  );
    logic [L-1:0] dx;
    logic [L-1:0] lim;
    dx  = x[L-1:0] - r.topid[L-1:0];
    lim = r.opid[L-1:0] - r.topid[L-1:0] + L'(1);
    return r.opid[15] & x[15] & (dx >= lim);
  endfunction

  // Classify each FU result as live or dead.
  always_comb begin
    w_dead = '0;
    w_live = '0;
    for (int i = 0; i < nfu; i++) begin
      w_dead[i] = squash(resp[i].opid, redir);
      w_live[i] = resp[i].opid[15] & ~w_dead[i];
    end
  end

  // Scan from ptr, grant up to wwd live inputs into wb slots.
  always_comb begin
    int          n;
    logic [PW-1:0] idx;
    w_gnt     = '0;
    w_wb_nxt  = '0;
    w_ptr_nxt = r_ptr;
    n         = 0;
    idx       = '0;
    for (int k = 0; k < nfu; k++) begin
      idx = PW'((int'(r_ptr) + k) % nfu);
      if (w_live[idx] && (n < wwd)) begin
        w_gnt[idx]         = 1'b1;
        w_wb_nxt[SW'(n)]   = resp[idx];
        w_ptr_nxt = PW'((int'(idx) + 1) % nfu);
        n = n + 1;
      end
    end
  end

  assign claim = w_gnt | w_dead;

  // Capture winners and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_wb  <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_wb  <= w_wb_nxt;
    end
  end

  // Mask captured results hit by a redirect arriving after capture.
  always_comb begin
    wb = r_wb;
    for (int j = 0; j < wwd; j++) begin
      if (squash(r_wb[j].opid, redir)) begin
        wb[j].opid = '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter
// plus a random fairness run.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int NFU = 4;
  localparam int WWD = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  red_bundle_t           redir;
  exe_bundle_t [NFU-1:0] resp;
  logic        [NFU-1:0] claim;
  exe_bundle_t [WWD-1:0] wb;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string                 name;
    logic        [NFU-1:0] claim;
    exe_bundle_t [WWD-1:0] wb;
  } exp_t;

  exp_t q[$];
  exp_t e;

  wb_arbiter #(
    .nfu (NFU),
    .wwd (WWD),
    .opsz(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .redir(redir),
    .resp (resp),
    .claim(claim),
    .wb   (wb)
  );

  always #5 clk = ~clk;

  function automatic exe_bundle_t mk(input logic [15:0] op);
    exe_bundle_t b;
    b = '0;
    if (op != 16'h0) begin
      b.opid = op;
      b.data = {16'hDA7A, op};
    end
    return b;
  endfunction

  task automatic drive(
    input string       nm,
    input logic        rv,
    input logic [15:0] o0,
    input logic [15:0] o1,
    input logic [15:0] o2,
    input logic [15:0] o3,
    input logic [15:0] ro,
    input logic [15:0] rt,
    input logic [3:0]  ec,
    input exe_bundle_t e0,
    input exe_bundle_t e1
  );
    exp_t x;
    @(posedge clk);
    #1;
    rst         = rv;
    resp[0]     = mk(o0);
    resp[1]     = mk(o1);
    resp[2]     = mk(o2);
    resp[3]     = mk(o3);
    redir.opid  = ro;
    redir.topid = rt;
    x.name  = nm;
    x.claim = ec;
    x.wb[0] = e0;
    x.wb[1] = e1;
    q.push_back(x);
  endtask

  // Scoreboard monitor: one expected record per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (claim !== e.claim) begin
        n_bad++;
        $display("FAIL %s claim: got %b want %b",
                 e.name, claim, e.claim);
      end
      n_cmp++;
      if (wb !== e.wb) begin
        n_bad++;
        $display("FAIL %s wb: got %h want %h",
                 e.name, wb, e.wb);
      end
    end
  end

  logic [NFU-1:0] pend;
  int             waitc [NFU];
  exe_bundle_t    z;
  exe_bundle_t    m0a;

  initial begin
    rst   = 1'b0;
    resp  = '0;
    redir = '0;
    z     = '0;
    m0a   = '0;
    m0a.data = 32'hDA7A800A;

    drive("reset",  0, 0, 0, 0, 0, 0, 0, 4'b0000, z, z);
    drive("c1",     1, 16'h8001, 16'h8002, 16'h8003, 16'h8004,
          0, 0, 4'b0011, z, z);
    drive("c2",     1, 0, 0, 16'h8003, 16'h8004,
          0, 0, 4'b1100, mk(16'h8001), mk(16'h8002));
    drive("c3",     1, 0, 0, 0, 0,
          0, 0, 4'b0000, mk(16'h8003), mk(16'h8004));
    drive("idle",   1, 0, 0, 0, 0, 0, 0, 4'b0000, z, z);
    drive("wrap3",  1, 0, 0, 0, 16'h8010,
          0, 0, 4'b1000, z, z);
    drive("one1",   1, 0, 16'h8011, 0, 0,
          0, 0, 4'b0010, mk(16'h8010), z);
    drive("scan2",  1, 16'h8020, 16'h8021, 0, 16'h8023,
          0, 0, 4'b1001, mk(16'h8011), z);
    drive("pend1",  1, 0, 16'h8021, 16'h8022, 0,
          0, 0, 4'b0110, mk(16'h8023), mk(16'h8020));
    drive("squash", 1, 0, 16'h8007, 16'h8003, 0,
          16'h8005, 16'h8000, 4'b0110,
          mk(16'h8021), mk(16'h8022));
    drive("sq_wb",  1, 0, 0, 0, 0,
          0, 0, 4'b0000, mk(16'h8003), z);
    drive("cap0a",  1, 16'h800A, 0, 0, 0,
          0, 0, 4'b0001, z, z);
    drive("late_sq", 1, 0, 0, 0, 0,
          16'h8008, 16'h8000, 4'b0000, m0a, z);
    drive("opwrap", 1, 0, 16'h8001, 16'h801F, 0,
          16'h801F, 16'h801E, 4'b0110, z, z);
    drive("opw_wb", 1, 0, 0, 0, 0,
          0, 0, 4'b0000, mk(16'h801F), z);
    drive("pre_rst", 1, 16'h8031, 16'h8032, 16'h8033, 16'h8034,
          0, 0, 4'b1001, z, z);
    drive("pre_rst2", 1, 0, 0, 0, 0,
          0, 0, 4'b0000, mk(16'h8034), mk(16'h8031));
    drive("mid_rst", 0, 16'h8050, 16'h8051, 16'h8052, 0,
          0, 0, 4'b0011, z, z);
    drive("post_rst", 1, 16'h8041, 16'h8042, 16'h8043, 16'h8044,
          0, 0, 4'b0011, z, z);
    drive("post_wb", 1, 0, 0, 0, 0,
          0, 0, 4'b0000, mk(16'h8041), mk(16'h8042));

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, want 0", q.size());
    end

    pend = '0;
    for (int i = 0; i < NFU; i++) waitc[i] = 0;
    redir = '0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NFU; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            pend[i] = 1'b1;
            resp[i] = mk(16'h8000 | 16'($urandom_range(0, 31)));
          end else begin
            resp[i] = '0;
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < NFU; i++) begin
        n_cmp++;
        if (pend[i]) begin
          if (claim[i]) begin
            pend[i]  = 1'b0;
            waitc[i] = 0;
          end else begin
            waitc[i]++;
          end
          if (waitc[i] > 2) begin
            n_bad++;
            $display("FAIL fair%0d: waited %0d cycles, want <=2",
                     i, waitc[i]);
          end
        end else if (claim[i]) begin
          n_bad++;
          $display("FAIL idle_claim%0d: got 1 want 0", i);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter nfu, 4, number of functional-unit response ports arbitrated.
REQ-002 Parameter wwd, 2, writeback width (results accepted per cycle), 1 <= wwd <= nfu.
REQ-003 Parameter opsz, 32, operation ID space size (power of two); L = $clog2(opsz).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 redir  input  red_bundle_t  redirect bundle (opid, topid).
REQ-007 resp  input  exe_bundle_t[nfu]  FU results; entry valid iff resp[i].opid[15].
REQ-008 claim  output  [nfu]  claim strobe per FU; FU dequeues its result on the cycle claim[i]=1.
REQ-009 wb  output  exe_bundle_t[wwd]  registered writeback results; slot valid iff wb[j].opid[15].

Function
REQ-010 squash(x) SHALL be true iff redir.opid[15] & x[15] & ((x[L-1:0]-redir.topid[L-1:0]) mod opsz >= (redir.opid[L-1:0]-redir.topid[L-1:0]+1) mod opsz).
REQ-011 Input i is live iff resp[i].opid[15] & ~squash(resp[i].opid); dead iff valid & squash.
REQ-012 Round-robin pointer ptr (width $clog2(nfu), reset 0) SHALL define scan order ptr, ptr+1, ..., ptr+nfu-1 mod nfu.
REQ-013 Grant: first min(wwd, #live) live inputs in scan order, assigned to wb slots 0,1,... in scan order.
REQ-014 claim[i] SHALL be combinational: 1 iff input i granted or dead; otherwise 0.
REQ-015 Dead inputs SHALL be claimed the same cycle, SHALL NOT consume a wb slot, SHALL never appear on wb.
REQ-016 Live inputs beyond the wwd granted SHALL get claim=0 and stay pending (FU holds them).
REQ-017 Next cycle, wb[j] SHALL equal the full bundle of the j-th granted input; unused slots SHALL be all-zero.
REQ-018 Latency: claim in cycle N -> wb valid in cycle N+1; exactly one cycle, no internal queue.
REQ-019 wb[j].opid SHALL be forced to 0 combinationally while squash(wb[j].opid) holds; other fields unchanged.
REQ-020 ptr update: if >=1 grant, ptr <= (index of last granted input + 1) mod nfu; else ptr unchanged.
REQ-021 No backpressure: wwd results SHALL be accepted every cycle; no input SHALL be passed over for more than ceil(nfu/wwd) consecutive cycles while live.
REQ-022 Simultaneous redirect and grant: squash evaluated with the current-cycle redir before grant; a result squashed in the cycle after capture is masked per REQ-019.
REQ-023 wrap-around: scan and ptr arithmetic modulo nfu; opid compare modulo opsz per REQ-010 (topid-relative, wrap-safe).
REQ-024 resp validity in a cycle with all inputs invalid: claim=0, next wb all-zero, ptr held.

Reset
REQ-025 On rst low, asynchronously: wb all-zero, ptr=0; claim depends only on inputs (combinational) and is not reset.
REQ-026 Reset mid-operation SHALL discard captured results; no wb valid in the first cycle after rst deasserts unless granted in that cycle's preceding edge.

Verification
REQ-027 nfu=4,wwd=2, ptr=0, resp[0..3] live opid 0x8001..0x8004 -> claim=0011, next wb opid {0x8001,0x8002}, ptr=2.
REQ-028 Same inputs held (FU2,3 pending), next cycle -> claim=1100, wb {0x8003,0x8004}, ptr=0; fairness check over 100 random cycles: no live input waits >2 cycles.
REQ-029 redir opid=0x8005 topid=0x8000, resp[1]=0x8007, resp[2]=0x8003 -> claim=0110, next wb {0x8003, 0}, 0x8007 never on wb.
REQ-030 wb[0]=0x800A captured; next cycle redir opid=0x8008 topid=0x8000 -> wb[0].opid reads 0 that cycle.
REQ-031 opid wrap: topid=0x801E, redir opid=0x801F, resp opid 0x8001 -> squashed (dead, claimed); resp 0x801F -> live, granted.
REQ-032 Assert rst low mid-stream with wb valid -> wb all-zero immediately, ptr=0; after release, first grant begins at input 0.
